// File: rtl/operand_fetch_if.sv
// Read-only view of the GPR file: the register file drives gpr[], operand fetch samples it combinationally.
interface gpr_if #(
    parameter int NREG = 32
);
    logic [31:0] gpr [NREG];

    modport master (output gpr);
    modport slave  (input  gpr);
endinterface

// File: rtl/operand_fetch.sv
// Dual-lane operand fetch with a per-GPR write-latency scoreboard (RAW/WAW stall).
// Latency: 1 cycle from an accepted bundle to out_valid.
// Backpressure: in_ready drops on hazard, interlock or flush; interlock freezes outputs and scoreboard.
module operand_fetch #(
    parameter int NREG = 32,
    parameter int LATW = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            interlock,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     pc_in,
    input  logic [63:0]     inst_in,
    input  logic [4:0]      u_rs_a,
    input  logic [4:0]      u_rs_b,
    input  logic [4:0]      u_rd,
    input  logic [LATW-1:0] u_lat,
    input  logic [4:0]      l_rs_a,
    input  logic [4:0]      l_rs_b,
    input  logic [4:0]      l_rd,
    input  logic [LATW-1:0] l_lat,
    gpr_if.slave            gpr,
    output logic            out_valid,
    output logic [31:0]     pc_out,
    output logic [63:0]     inst_out,
    output logic [31:0]     u_opa,
    output logic [31:0]     u_opb,
    output logic [31:0]     l_opa,
    output logic [31:0]     l_opb,
    output logic [4:0]      u_rd_out,
    output logic [4:0]      l_rd_out,
    output logic            u_rd_flag,
    output logic            l_rd_flag,
    output logic            hazard
);
    localparam logic [LATW-1:0] ONE = LATW'(1);

    logic [LATW-1:0] r_cnt [NREG];
    logic            r_out_valid;
    logic [31:0]     r_pc;
    logic [63:0]     r_inst;
    logic [31:0]     r_u_opa, r_u_opb, r_l_opa, r_l_opb;
    logic [4:0]      r_u_rd, r_l_rd;
    logic            r_u_flag, r_l_flag;

    logic            w_raw, w_waw_u, w_waw_l, w_hazard, w_issue;
    logic            w_u_wr, w_l_wr;
    logic [LATW-1:0] w_u_ld, w_l_ld;

    assign w_u_wr   = (u_lat != '0);
    assign w_l_wr   = (l_lat != '0);
    assign w_raw    = (r_cnt[u_rs_a] != '0) || (r_cnt[u_rs_b] != '0) ||
                      (r_cnt[l_rs_a] != '0) || (r_cnt[l_rs_b] != '0);
    // A new write must not land before an older pending write to the same register.
    assign w_waw_u  = w_u_wr && (r_cnt[u_rd] > u_lat);
    assign w_waw_l  = w_l_wr && (r_cnt[l_rd] > l_lat);
    assign w_hazard = in_valid && (w_raw || w_waw_u || w_waw_l);
    assign w_issue  = in_valid && !w_hazard && !interlock && !flush;

    // Both lanes targeting one register: the later-landing write defines the counter.
    assign w_u_ld = (w_l_wr && (l_rd == u_rd) && (l_lat > u_lat)) ? l_lat : u_lat;
    assign w_l_ld = (w_u_wr && (l_rd == u_rd) && (u_lat > l_lat)) ? u_lat : l_lat;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_inst      <= '0;
            r_u_opa     <= '0;
            r_u_opb     <= '0;
            r_l_opa     <= '0;
            r_l_opb     <= '0;
            r_u_rd      <= '0;
            r_l_rd      <= '0;
            r_u_flag    <= 1'b0;
            r_l_flag    <= 1'b0;
        end else if (!interlock) begin
            for (int i = 0; i < NREG; i++)
                r_cnt[i] <= (r_cnt[i] == '0) ? '0 : r_cnt[i] - ONE;
            r_out_valid <= w_issue;
            if (w_issue) begin
                if (w_u_wr) r_cnt[u_rd] <= w_u_ld;
                if (w_l_wr) r_cnt[l_rd] <= w_l_ld;
                r_pc     <= pc_in;
                r_inst   <= inst_in;
                r_u_opa  <= gpr.gpr[u_rs_a];
                r_u_opb  <= gpr.gpr[u_rs_b];
                r_l_opa  <= gpr.gpr[l_rs_a];
                r_l_opb  <= gpr.gpr[l_rs_b];
                r_u_rd   <= u_rd;
                r_l_rd   <= l_rd;
                r_u_flag <= w_u_wr;
                r_l_flag <= w_l_wr;
            end
        end
    end

    assign in_ready  = w_issue;
    assign hazard    = w_hazard;
    assign out_valid = r_out_valid;
    assign pc_out    = r_pc;
    assign inst_out  = r_inst;
    assign u_opa     = r_u_opa;
    assign u_opb     = r_u_opb;
    assign l_opa     = r_l_opa;
    assign l_opb     = r_l_opb;
    assign u_rd_out  = r_u_rd;
    assign l_rd_out  = r_l_rd;
    assign u_rd_flag = r_u_flag;
    assign l_rd_flag = r_l_flag;
endmodule
